// File: rtl/rcs_4b_reg.sv
// 4-bit ripple-borrow subtractor (diff = a - b - cin) with a single registered output stage.
// Reset clears the result, the borrow and the valid flag. Idle cycles hold the last result.
module rcs_4b_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] diff,
    output logic       bout,
    output logic       out_valid
);

    // One full-subtractor cell. Returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
        fs_cell = {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
    endfunction

    logic [4:0] br_p0;
    logic [3:0] diff_p0;
    logic [3:0] diff_p1;
    logic       bout_p1;
    logic       vld_p1;

    // Stage p0: combinational borrow ripple, bit 0 fed by cin
    always_comb begin
        br_p0    = '0;
        diff_p0  = '0;
        br_p0[0] = cin;
        for (int i = 0; i < 4; i++) begin
            {br_p0[i+1], diff_p0[i]} = fs_cell(a[i], b[i], br_p0[i]);
        end
    end

    // Stage p1: output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            diff_p1 <= 4'b0000;
            bout_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                diff_p1 <= diff_p0;
                bout_p1 <= br_p0[4];
            end
        end
    end

    assign diff      = diff_p1;
    assign bout      = bout_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rcs_4b_reg.sv
// Scoreboard bench for rcs_4b_reg: the driver queues the expected registered outputs for
// every cycle it drives, and a monitor pops and compares one entry after each rising edge.
module tb_rcs_4b_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] diff;
    logic       bout;
    logic       out_valid;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       bo;
        string      tag;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Bench-side view of the registered state, used for hold and reset expectations.
    logic [3:0] m_diff;
    logic       m_bout;

    rcs_4b_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
    task automatic apply(input logic rn, input logic iv, input logic [3:0] ta, input logic [3:0] tb_,
                         input logic tc, input logic [3:0] ed, input logic eb, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n    = rn;
        in_valid = iv;
        a        = ta;
        b        = tb_;
        cin      = tc;
        if (!rn) begin
            m_diff = 4'b0000;
            m_bout = 1'b0;
            e.v    = 1'b0;
        end else if (iv) begin
            m_diff = ed;
            m_bout = eb;
            e.v    = 1'b1;
        end else begin
            e.v    = 1'b0;
        end
        e.d   = m_diff;
        e.bo  = m_bout;
        e.tag = tag;
        expq.push_back(e);
    endtask

    // Monitor: compare every registered output one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (out_valid !== e.v || diff !== e.d || bout !== e.bo) begin
                    errors++;
                    $display("FAIL %s: got vld=%b diff=%b bout=%b, expected vld=%b diff=%b bout=%b",
                             e.tag, out_valid, diff, bout, e.v, e.d, e.bo);
                end
            end
        end
    end

    initial begin
        logic [8:0] v;
        logic [4:0] r;
        int         drain;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'b0000;
        b        = 4'b0000;
        cin      = 1'b0;
        m_diff   = 4'b0000;
        m_bout   = 1'b0;

        // Reset held with valid data present
        apply(1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 4'b0000, 1'b0, "reset0");
        apply(1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 4'b0000, 1'b0, "reset1");

        // No-borrow sequence
        apply(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "nb_0_0");
        apply(1'b1, 1'b1, 4'b1100, 4'b1001, 1'b0, 4'b0011, 1'b0, "nb_12_9");
        apply(1'b1, 1'b1, 4'b1011, 4'b1000, 1'b0, 4'b0011, 1'b0, "nb_11_8");
        apply(1'b1, 1'b1, 4'b1001, 4'b0110, 1'b0, 4'b0011, 1'b0, "nb_9_6");
        apply(1'b1, 1'b1, 4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0, "nb_7_1");

        // Borrow out
        apply(1'b1, 1'b1, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, "bo_3_5");
        apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b1, "bo_0_15");

        // Borrow in and boundary cases
        apply(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "bi_0_0_1");
        apply(1'b1, 1'b1, 4'b1000, 4'b0011, 1'b1, 4'b0100, 1'b0, "bi_8_3_1");
        apply(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "bd_15_15_1");
        apply(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, "bd_0_15_1");
        apply(1'b1, 1'b1, 4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b0, "bd_7_7_0");

        // Hold: valid result, then idle cycles with changing operands
        apply(1'b1, 1'b1, 4'b1100, 4'b1001, 1'b0, 4'b0011, 1'b0, "hold_load");
        apply(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, "hold_idle1");
        apply(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, "hold_idle2");

        // Exhaustive sweep with a reset pulse in the middle
        for (int i = 0; i < 512; i++) begin
            if (i == 300)
                apply(1'b0, 1'b1, 4'b0101, 4'b1010, 1'b0, 4'b0000, 1'b0, "ex_reset");
            v = 9'(i);
            r = {1'b0, v[3:0]} - {1'b0, v[7:4]} - {4'b0000, v[8]};
            apply(1'b1, 1'b1, v[3:0], v[7:4], v[8], r[3:0], r[4], $sformatf("ex_%0d", i));
        end

        @(negedge clk);
        in_valid = 1'b0;
        drain = 0;
        while (expq.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
